// File: rtl/hgw_apb2reg_ws_if.sv
// APB slave-side bus bundle for hgw_apb2reg_ws.
// The bridge uses the slave modport and the requester uses the master modport.
interface hgw_apb2reg_ws_if #(
  parameter int BW = 16,
  parameter int DW = 32
);
  logic [BW-1:0]   paddr;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic            pready;
  logic [DW-1:0]   prdata;
  logic            pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/hgw_apb2reg_ws.sv
// APB-to-register bridge: zero-wait writes, reads wait for i_rvalid, all outputs registered.
// Optional read timeout is enabled by defining HGW_APB2REG_TIMEOUT_EN.
module hgw_apb2reg_ws #(
  parameter int            BW       = 16,
  parameter int            DW       = 32,
  parameter logic [BW-1:0] ADDR_MAX = 16'h0FFC,
  parameter int            TO_CYC   = 16
) (
  input  logic            pclk,
  input  logic            presetn,
  hgw_apb2reg_ws_if.slave apb,
  output logic            o_wen,
  output logic            o_ren,
  output logic [BW-1:0]   o_waddr,
  output logic [BW-1:0]   o_raddr,
  output logic [DW-1:0]   o_wdata,
  output logic [DW/8-1:0] o_wstrb,
  input  logic [DW-1:0]   i_rdata,
  input  logic            i_rvalid
);

  if ((TO_CYC < 1) || (TO_CYC > 255) || ((DW % 8) != 0)) begin : g_param_check
    $error("hgw_apb2reg_ws: TO_CYC must be 1..255 and DW a multiple of 8");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]      state_q,   state_d;
  logic [BW-1:0]   addr_q,    addr_d;
  logic [DW-1:0]   wdata_q,   wdata_d;
  logic [DW/8-1:0] wstrb_q,   wstrb_d;
  logic            pready_q,  pready_d;
  logic            pslverr_q, pslverr_d;
  logic [DW-1:0]   prdata_q,  prdata_d;
  logic            wen_q,     wen_d;
  logic            ren_q,     ren_d;
`ifdef HGW_APB2REG_TIMEOUT_EN
  logic [7:0]      cnt_q,     cnt_d;
`endif

  // Next-state and next-output decode; each output is computed one cycle ahead
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = {DW{1'b0}};
    wen_d     = 1'b0;
    ren_d     = 1'b0;
`ifdef HGW_APB2REG_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (apb.psel && !apb.penable) begin
          addr_d  = apb.paddr;
          wdata_d = apb.pwdata;
          wstrb_d = apb.pstrb;
          if (apb.paddr > ADDR_MAX) begin
            state_d   = ST_RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else if (apb.pwrite) begin
            state_d  = ST_WR;
            pready_d = 1'b1;
            wen_d    = 1'b1;
          end else begin
            state_d = ST_RD;
            ren_d   = 1'b1;
`ifdef HGW_APB2REG_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        state_d = ST_IDLE;
      end
      // A dropped psel abandons the read even if data arrives in the same cycle
      ST_RD: begin
        if (!apb.psel) begin
          state_d = ST_IDLE;
        end else if (i_rvalid) begin
          state_d  = ST_RESP;
          pready_d = 1'b1;
          prdata_d = i_rdata;
`ifdef HGW_APB2REG_TIMEOUT_EN
        end else if (cnt_q == 8'(TO_CYC - 1)) begin
          state_d   = ST_RESP;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`else
        end else begin
          state_d = ST_RD;
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= ST_IDLE;
      addr_q    <= {BW{1'b0}};
      wdata_q   <= {DW{1'b0}};
      wstrb_q   <= {(DW/8){1'b0}};
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= {DW{1'b0}};
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
`ifdef HGW_APB2REG_TIMEOUT_EN
      cnt_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
`ifdef HGW_APB2REG_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata  = prdata_q;
  assign o_wen       = wen_q;
  assign o_ren       = ren_q;
  assign o_waddr     = addr_q;
  assign o_raddr     = addr_q;
  assign o_wdata     = wdata_q;
  assign o_wstrb     = wstrb_q;

endmodule
